// File: rtl/smc_sorter.sv
// rtl/smc_sorter.sv - six-word descending insertion sorter feeding the SMC output chooser
//
// Purpose: accepts six WIDTH-bit words serially, insertion-sorts them into
// descending order, and presents the sorted group plus the mode captured with
// the first word as a registered bundle, flagged by a one-cycle out_valid.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - in_data (and mode_in on the first word) offered this cycle
//   in_data   - unsigned word to insert
//   mode_in   - group mode, sampled only with the first word of a group
//   in_ready  - a word is accepted this cycle when in_valid is also high
//   out_valid - one-cycle pulse marking a complete sorted group on n0..n5
//   mode_out  - mode latched with the first word of the group
//   n0..n5    - sorted group, n0 largest, n5 smallest; held until next group

module smc_sorter #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       mode_in,
   output logic             in_ready,
   output logic             out_valid,
   output logic [1:0]       mode_out,
   output logic [WIDTH-1:0] n0,
   output logic [WIDTH-1:0] n1,
   output logic [WIDTH-1:0] n2,
   output logic [WIDTH-1:0] n3,
   output logic [WIDTH-1:0] n4,
   output logic [WIDTH-1:0] n5
);

   typedef enum logic {
      S_FILL = 1'b0,
      S_OUT  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [2:0]       r_count;
   logic [1:0]       r_mode_pend;
   logic [1:0]       r_mode_out;
   logic [WIDTH-1:0] r_arr [6];
   logic [WIDTH-1:0] r_n   [6];
   logic [WIDTH-1:0] w_ins [6];
   logic [2:0]       w_pos;
   logic             w_xfer;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_FILL: begin
            in_ready = 1'b1;
            if (in_valid && (r_count == 3'd5)) begin
               w_next = S_OUT;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            w_next    = S_FILL;
         end
         default: begin
            w_next = S_FILL;
         end
      endcase
   end

   assign w_xfer = in_valid & in_ready;

   // The array is kept sorted, so "new word beats slot k" is true for a
   // contiguous tail of occupied slots; the lowest such k is the landing slot.
   // Scanning downward lets the last hit win. Equal values never win, which
   // places the new word after existing equals.
   always_comb begin
      w_pos = r_count;
      for (int k = 5; k >= 0; k--) begin
         if ((3'(k) < r_count) && (in_data > r_arr[k])) begin
            w_pos = 3'(k);
         end
      end
   end

   // Slots above the landing point keep their place, the landing slot takes the
   // new word, and everything below shifts down by one. Unoccupied slots hold
   // zero, so shifting them in is harmless.
   always_comb begin
      w_ins[0] = (w_pos == 3'd0) ? in_data : r_arr[0];
      for (int k = 1; k < 6; k++) begin
         w_ins[k] = r_arr[k];
         if (3'(k) == w_pos) begin
            w_ins[k] = in_data;
         end else if (3'(k) > w_pos) begin
            w_ins[k] = r_arr[k-1];
         end
      end
   end

   // Datapath: insertion array, counter, mode capture, output bundle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= 3'd0;
         r_mode_pend <= 2'd0;
         r_mode_out  <= 2'd0;
         for (int k = 0; k < 6; k++) begin
            r_arr[k] <= '0;
            r_n[k]   <= '0;
         end
      end else if (w_xfer) begin
         if (r_count == 3'd5) begin
            r_n        <= w_ins;
            r_mode_out <= r_mode_pend;
            r_count    <= 3'd0;
            for (int k = 0; k < 6; k++) begin
               r_arr[k] <= '0;
            end
         end else begin
            r_arr   <= w_ins;
            r_count <= r_count + 3'd1;
            if (r_count == 3'd0) begin
               r_mode_pend <= mode_in;
            end
         end
      end
   end

   assign mode_out = r_mode_out;
   assign n0       = r_n[0];
   assign n1       = r_n[1];
   assign n2       = r_n[2];
   assign n3       = r_n[3];
   assign n4       = r_n[4];
   assign n5       = r_n[5];

endmodule

// File: tb/tb_smc_sorter.sv
// tb/tb_smc_sorter.sv - self-checking bench for smc_sorter with a queue-based sort model

module tb_smc_sorter;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [9:0] in_data;
   logic [1:0] mode_in;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] mode_out;
   logic [9:0] n0, n1, n2, n3, n4, n5;

   always #5 clk = ~clk;

   smc_sorter #(.WIDTH(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .mode_in   (mode_in),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .mode_out  (mode_out),
      .n0        (n0),
      .n1        (n1),
      .n2        (n2),
      .n3        (n3),
      .n4        (n4),
      .n5        (n5)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   bit         chk_en = 0;
   int         cyc = 0;
   int         pulses = 0;
   int         pulse_cyc[$];

   // Reference model state
   logic [9:0] mq[$];
   logic [1:0] m_pend;
   logic [1:0] e_mode;
   logic [9:0] e_n[6];
   bit         e_valid;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare current outputs with the model, then advance the model with the
   // inputs that the next rising edge will sample.
   initial begin
      logic [9:0] s[6];
      logic [9:0] tmp;
      e_valid = 0;
      e_mode  = 0;
      m_pend  = 0;
      for (int i = 0; i < 6; i++) e_n[i] = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(e_valid));
            chk("in_ready",  64'(in_ready),  64'(!e_valid));
            chk("mode_out",  64'(mode_out),  64'(e_mode));
            chk("n0", 64'(n0), 64'(e_n[0]));
            chk("n1", 64'(n1), 64'(e_n[1]));
            chk("n2", 64'(n2), 64'(e_n[2]));
            chk("n3", 64'(n3), 64'(e_n[3]));
            chk("n4", 64'(n4), 64'(e_n[4]));
            chk("n5", 64'(n5), 64'(e_n[5]));
         end
         if (out_valid === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
         end
         if (rst) begin
            mq.delete();
            e_valid = 0;
            e_mode  = 0;
            for (int i = 0; i < 6; i++) e_n[i] = 0;
         end else if (e_valid) begin
            e_valid = 0;
         end else if (in_valid) begin
            if (mq.size() == 0) m_pend = mode_in;
            mq.push_back(in_data);
            if (mq.size() == 6) begin
               for (int i = 0; i < 6; i++) s[i] = mq[i];
               for (int i = 0; i < 5; i++) begin
                  for (int j = 0; j < 5 - i; j++) begin
                     if (s[j] < s[j+1]) begin
                        tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
                     end
                  end
               end
               for (int i = 0; i < 6; i++) e_n[i] = s[i];
               e_mode  = m_pend;
               e_valid = 1;
               mq.delete();
            end
         end
      end
   end

   task automatic send(input logic [9:0] d, input logic [1:0] m);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      mode_in  = m;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   // Wait (bounded) for out_valid, then check literal expectations and hold.
   task automatic expect_group(input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                               input logic [9:0] e3, input logic [9:0] e4, input logic [9:0] e5,
                               input logic [1:0] em);
      int t;
      t = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("lit_valid", 64'(out_valid), 64'd1);
      chk("lit_n0", 64'(n0), 64'(e0));
      chk("lit_n1", 64'(n1), 64'(e1));
      chk("lit_n2", 64'(n2), 64'(e2));
      chk("lit_n3", 64'(n3), 64'(e3));
      chk("lit_n4", 64'(n4), 64'(e4));
      chk("lit_n5", 64'(n5), 64'(e5));
      chk("lit_mode", 64'(mode_out), 64'(em));
      @(negedge clk);
      chk("lit_valid_drop", 64'(out_valid), 64'd0);
      chk("lit_hold_n0", 64'(n0), 64'(e0));
      chk("lit_hold_n5", 64'(n5), 64'(e5));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int c0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      mode_in  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_n0", 64'(n0), 64'd0);
      chk("rst_mode", 64'(mode_out), 64'd0);

      // Basic sort, later mode_in values ignored
      send(5, 2'b01); send(900, 2'b10); send(17, 2'b11);
      send(1023, 2'b10); send(0, 2'b00); send(300, 2'b11);
      idle(1);
      expect_group(1023, 900, 300, 17, 5, 0, 2'b01);

      // Duplicates and extremes
      send(7, 2'b10); send(7, 2'b00); send(1023, 2'b00);
      send(7, 2'b00); send(0, 2'b00); send(1023, 2'b00);
      idle(1);
      expect_group(1023, 1023, 7, 7, 7, 0, 2'b10);

      // Gaps and mode sampling
      p0 = pulses;
      send(1, 2'b11); send(2, 2'b00);
      idle(3);
      send(3, 2'b00); send(4, 2'b00); send(5, 2'b00); send(6, 2'b00);
      idle(1);
      expect_group(6, 5, 4, 3, 2, 1, 2'b11);
      idle(4);
      chk("gap_pulses", 64'(pulses - p0), 64'd1);

      // Back-to-back: 13 continuous offers
      p0 = pulses;
      c0 = pulse_cyc.size();
      for (int i = 0; i < 13; i++) send(10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)));
      idle(4);
      chk("b2b_pulses", 64'(pulses - p0), 64'd2);
      if (pulse_cyc.size() >= c0 + 2)
         chk("b2b_spacing", 64'(pulse_cyc[c0+1] - pulse_cyc[c0]), 64'd7);
      else
         chk("b2b_spacing", 64'(pulse_cyc.size() - c0), 64'd2);

      // Reset mid-group, word offered with rst is dropped
      p0 = pulses;
      send(500, 2'b10); send(600, 2'b00); send(700, 2'b00);
      @(posedge clk);
      #1 rst = 1'b1; in_valid = 1'b1; in_data = 10'd999;
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      chk("midrst_no_pulse", 64'(pulses - p0), 64'd0);
      send(10, 2'b01); send(20, 2'b00); send(30, 2'b00);
      send(40, 2'b00); send(50, 2'b00); send(60, 2'b00);
      idle(1);
      expect_group(60, 50, 40, 30, 20, 10, 2'b01);

      // Reset during OUT, with in_valid high
      send(100, 2'b10); send(200, 2'b00); send(300, 2'b00);
      send(400, 2'b00); send(500, 2'b00); send(600, 2'b00);
      @(posedge clk);
      #1 rst = 1'b1; in_valid = 1'b1; in_data = 10'd999;
      @(negedge clk);
      chk("outrst_pre_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("outrst_valid", 64'(out_valid), 64'd0);
      chk("outrst_n0", 64'(n0), 64'd0);
      chk("outrst_mode", 64'(mode_out), 64'd0);
      send(11, 2'b11); send(22, 2'b00); send(33, 2'b00);
      send(44, 2'b00); send(55, 2'b00); send(66, 2'b00);
      idle(1);
      expect_group(66, 55, 44, 33, 22, 11, 2'b11);

      // Randomized groups with gaps, duplicates and extremes
      for (int g = 0; g < 30; g++) begin
         for (int w = 0; w < 6; w++) begin
            logic [9:0] d;
            case ($urandom_range(0, 5))
               0: d = 10'd0;
               1: d = 10'd1023;
               2: d = 10'($urandom_range(0, 3));
               default: d = 10'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(d, 2'($urandom_range(0, 3)));
         end
         idle($urandom_range(1, 3));
      end
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/smc_sorter.md
Name: smc_sorter

Overview:
- Upstream stage of the SMC output chooser.
- Collects six WIDTH-bit results that arrive serially, one per accepted cycle, together with a 2-bit mode.
- Insertion-sorts them into descending order: n0 is the largest, n5 the smallest.
- Presents the six sorted values plus the latched mode as a registered, one-cycle-valid bundle to the chooser.

Parameters:
- WIDTH, 10, bit width of each data word and of each sorted output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data (and mode_in on the first word) is offered this cycle
- in_data  input  WIDTH  unsigned word to insert
- mode_in  input  2  mode for the group; sampled only with the first word of a group
- in_ready  output  1  block accepts a word this cycle; transfer = in_valid & in_ready
- out_valid  output  1  one-cycle pulse: n0..n5 and mode_out hold a complete sorted group
- mode_out  output  2  mode latched with the first word of the group
- n0..n5  output  WIDTH each  sorted group, n0 ≥ n1 ≥ … ≥ n5

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, state=FILL, internal array cleared to 0.
  - in_ready=1, out_valid=0, mode_out=0, n0..n5=0.
  - A reset mid-group discards the partial group; no out_valid is produced for it.
- States:
  - FILL: in_ready=1.
    - Transfer with count<5: insert the word, count+1.
    - Transfer with count==5 (sixth word): load the final sorted array, including the new word, into the n0..n5 output registers; load mode_out; set out_valid; clear the internal array; count=0; go to OUT.
  - OUT: lasts exactly one cycle. out_valid=1 and in_ready=0; in_valid is ignored, nothing is captured. Next edge: out_valid=0, back to FILL.
- Mode capture: mode_in is latched into a pending register on the transfer with count==0. mode_in at any other transfer is ignored. The pending mode is copied to mode_out when the sixth word is accepted.
- Insertion:
  - Every occupied slot k compares against the new word. If the new word is strictly greater than slot k, slot k shifts to k+1.
  - The new word lands at the first slot whose value it strictly exceeds, otherwise at slot count.
  - Ties: the new word goes after existing equal values, so the sort is stable.
  - Comparison is unsigned over the full WIDTH. Each insertion completes in one cycle; there are no multi-cycle compares.
- Gaps: in_valid may drop between words of a group; count and the array hold their values.
- Latency: out_valid rises in the cycle after the edge that captured the sixth word. Minimum group period is 7 cycles: 6 FILL transfers plus 1 OUT.
- Output hold: n0..n5 and mode_out keep their values after out_valid falls, until the next group completes or reset.
- Simultaneous events:
  - rst=1 together with in_valid=1: reset wins and the word is dropped.
  - rst during OUT: out_valid goes to 0 at that edge.
- No overflow or wrap: count never exceeds 5 because the sixth transfer always goes to OUT.

Test Plan:
- Reset then basic sort: mode_in=2'b01 with words 5, 900, 17, 1023, 0, 300 on consecutive cycles. Required: next cycle out_valid=1, n0..n5 = 1023, 900, 300, 17, 5, 0, mode_out=01. out_valid=0 the following cycle; values held.
- Duplicates and extremes: words 7, 7, 1023, 7, 0, 1023 with mode_in=2'b10. Required: n0..n5 = 1023, 1023, 7, 7, 7, 0, mode_out=10.
- Gaps and mode sampling: six words 1..6 with in_valid dropped for 3 cycles between words 2 and 3. mode_in=2'b11 on word 1, 2'b00 on the others. Required: n0..n5 = 6, 5, 4, 3, 2, 1, mode_out=11, out_valid exactly once.
- Back-to-back groups: hold in_valid=1 continuously for 13 cycles.
  - Cycles 1–6 accepted; cycle 7 is OUT with in_ready=0 and the word dropped; cycles 8–13 form the second group.
  - Required: two out_valid pulses, 7 cycles apart.
- Reset mid-group: 3 words, then rst for 1 cycle, then words 10, 20, 30, 40, 50, 60. Required: no out_valid before the reset; after it, n0..n5 = 60, 50, 40, 30, 20, 10.
- Reset during OUT and with in_valid: assert rst in the OUT cycle. Required: out_valid=0 and n0..n5=0 after that edge; a word offered with rst=1 is not counted.
